// File: rtl/ff_pipeline_sync_reset.sv
// Elastic register pipeline with per-stage valid bits, bubble collapsing and
// a combinational ready path; reset is synchronous and clears every stage.
module ff_pipeline_sync_reset #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           d,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           q,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCCW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] advance;
    logic [DEPTH-1:0] capture;
    logic             blocked;
    logic             accept;
    logic             emit;

    // A stage is blocked only when every stage after it is occupied and the
    // sink is not taking data, which unrolls the ripple-back advance chain.
    always_comb begin
        blocked = 1'b0;
        advance = '0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = !out_ready;
            for (int j = i + 1; j < DEPTH; j++) begin
                blocked = blocked & valid[j];
            end
            advance[i] = valid[i] & ~blocked;
        end
    end

    assign in_ready  = !valid[0] || advance[0];
    assign accept    = in_valid && in_ready;
    assign emit      = advance[DEPTH-1];
    assign q         = data[DEPTH-1];
    assign out_valid = valid[DEPTH-1];

    always_comb begin
        capture    = '0;
        capture[0] = accept;
        for (int i = 1; i < DEPTH; i++) begin
            capture[i] = advance[i-1];
        end
    end

    // A stage that hands its item on goes empty unless it refills on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid     <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (capture[i]) begin
                    valid[i] <= 1'b1;
                end else if (advance[i]) begin
                    valid[i] <= 1'b0;
                end
            end
            if (capture[0]) begin
                data[0] <= d;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (capture[i]) begin
                    data[i] <= data[i-1];
                end
            end
            if (accept && !emit) begin
                occupancy <= occupancy + OCCW'(1);
            end else if (!accept && emit) begin
                occupancy <= occupancy - OCCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ff_pipeline_sync_reset.sv
// Bench for ff_pipeline_sync_reset: an 8x3 instance against an item-position
// queue model, plus a 1x1 instance driven directly.
module tb_ff_pipeline_sync_reset;

    localparam int         D  = 3;
    localparam logic [7:0] RV = 8'hA5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] d = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] q;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] occupancy;

    logic       reset1 = 1'b0;
    logic [0:0] d1 = '0;
    logic       iv1 = 1'b0;
    logic       ir1;
    logic [0:0] q1;
    logic       ov1;
    logic       or1 = 1'b0;
    logic [0:0] occ1;

    int errors = 0;
    int checks = 0;

    // Model: each queued item carries the stage it sits in; head is oldest.
    int         mpos[$];
    logic [7:0] mval[$];
    int         npos[$];
    logic [7:0] lastq = RV;
    logic       exp_ready;
    logic       obs_ready;
    logic       exp_valid;
    logic [7:0] exp_q;
    logic [1:0] exp_occ;

    always #5 clock = ~clock;

    ff_pipeline_sync_reset #(.WIDTH(8), .DEPTH(D), .RESET_VALUE(RV)) dut (
        .clock(clock), .reset(reset), .d(d), .in_valid(in_valid), .in_ready(in_ready),
        .q(q), .out_valid(out_valid), .out_ready(out_ready), .occupancy(occupancy)
    );

    ff_pipeline_sync_reset #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b0)) dut1 (
        .clock(clock), .reset(reset1), .d(d1), .in_valid(iv1), .in_ready(ir1),
        .q(q1), .out_valid(ov1), .out_ready(or1), .occupancy(occ1)
    );

    // Each item moves one stage forward per cycle but may not land on or pass
    // the position the item ahead of it ends up in; the head leaves when shown and taken.
    task automatic predict(input logic orr);
        int limit;
        int np;
        limit = D - 1;
        npos.delete();
        for (int k = 0; k < mpos.size(); k++) begin
            if (k == 0 && mpos[0] == D - 1 && orr) begin
                npos.push_back(-1);
            end else begin
                np = (mpos[k] + 1 < limit) ? mpos[k] + 1 : limit;
                npos.push_back(np);
                limit = np - 1;
            end
        end
        exp_ready = (limit >= 0);
    endtask

    task automatic applyStimulus(input logic r, input logic iv, input logic [7:0] dv, input logic orr);
        int         tp[$];
        logic [7:0] tv[$];
        reset     = r;
        in_valid  = iv;
        d         = dv;
        out_ready = orr;
        predict(orr);
        #1;
        obs_ready = in_ready;
        @(posedge clock);
        #1;
        if (r) begin
            mpos.delete();
            mval.delete();
            lastq = RV;
        end else begin
            for (int k = 0; k < mpos.size(); k++) begin
                if (npos[k] >= 0) begin
                    tp.push_back(npos[k]);
                    tv.push_back(mval[k]);
                end
            end
            if (iv && exp_ready) begin
                tp.push_back(0);
                tv.push_back(dv);
            end
            mpos = tp;
            mval = tv;
            if (mpos.size() > 0 && mpos[0] == D - 1) lastq = mval[0];
        end
        exp_valid = (mpos.size() > 0 && mpos[0] == D - 1);
        exp_q     = lastq;
        exp_occ   = 2'(mpos.size());
    endtask

    task automatic flush();
        for (int i = 0; i < 8 && mpos.size() > 0; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b1, 8'h11, 1'b0);
        checks++; if (q !== 8'hA5) begin errors++; $display("[TB] FAIL reset_q: got %h expected %h", q, 8'hA5); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_streaming();
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(1'b0, c <= 4, 8'(c), 1'b1);
            checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready c%0d: got %b expected 1", c, obs_ready); end
            checks++; if (out_valid !== (c >= 3)) begin errors++; $display("[TB] FAIL stream_valid c%0d: got %b expected %b", c, out_valid, c >= 3); end
            if (c >= 3) begin
                checks++; if (q !== 8'(c - 2)) begin errors++; $display("[TB] FAIL stream_q c%0d: got %h expected %h", c, q, 8'(c - 2)); end
            end
            checks++; if (occupancy !== exp_occ) begin errors++; $display("[TB] FAIL stream_occ c%0d: got %0d expected %0d", c, occupancy, exp_occ); end
        end
    endtask

    task automatic test_full_stall();
        flush();
        applyStimulus(1'b0, 1'b1, 8'h10, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h20, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h30, 1'b0);
        checks++; if (occupancy !== 2'd3) begin errors++; $display("[TB] FAIL full_occ: got %0d expected 3", occupancy); end
        checks++; if (q !== 8'h10 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_head: got %h/%b expected 10/1", q, out_valid); end
        applyStimulus(1'b0, 1'b1, 8'h99, 1'b0);
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %b expected 0", obs_ready); end
        checks++; if (q !== 8'h10 || occupancy !== 2'd3) begin errors++; $display("[TB] FAIL stall_hold: got %h/%0d expected 10/3", q, occupancy); end
        applyStimulus(1'b0, 1'b1, 8'h40, 1'b1);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_passthru_ready: got %b expected 1", obs_ready); end
        checks++; if (occupancy !== 2'd3 || q !== 8'h20) begin errors++; $display("[TB] FAIL full_passthru: got %0d/%h expected 3/20", occupancy, q); end
        checks++; if (mval.size() != 3 || mval[2] !== 8'h40) begin errors++; $display("[TB] FAIL full_model_tail: got %0d items expected 40 at tail", mval.size()); end
    endtask

    task automatic test_bubble();
        flush();
        applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hBB, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("[TB] FAIL bubble_occ: got %0d expected 2", occupancy); end
        checks++; if (q !== 8'hAA || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bubble_head: got %h/%b expected aa/1", q, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bubble_in_ready: got %b expected 1", in_ready); end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (q !== 8'hBB || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bubble_next: got %h/%b expected bb/1", q, out_valid); end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b0, 1'b1, 8'hCC, 1'b0);
        checks++; if (occupancy !== 2'd2) begin errors++; $display("[TB] FAIL mid_pre_occ: got %0d expected 2", occupancy); end
        applyStimulus(1'b1, 1'b1, 8'hDD, 1'b1);
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_state: got %0d/%b expected 0/0", occupancy, out_valid); end
        checks++; if (q !== 8'hA5) begin errors++; $display("[TB] FAIL mid_reset_q: got %h expected a5", q); end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (obs_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_after: got ready %b valid %b expected 1/0", obs_ready, out_valid); end
    endtask

    task automatic test_random();
        logic r;
        logic iv;
        logic orr;
        for (int n = 0; n < 500; n++) begin
            r   = ($urandom_range(0, 59) == 0);
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 2) != 0);
            applyStimulus(r, iv, 8'($urandom), orr);
            if (!r) begin
                checks++; if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL rand_ready n%0d: got %b expected %b", n, obs_ready, exp_ready); end
            end
            checks++; if (out_valid !== exp_valid) begin errors++; $display("[TB] FAIL rand_valid n%0d: got %b expected %b", n, out_valid, exp_valid); end
            checks++; if (q !== exp_q) begin errors++; $display("[TB] FAIL rand_q n%0d: got %h expected %h", n, q, exp_q); end
            checks++; if (occupancy !== exp_occ) begin errors++; $display("[TB] FAIL rand_occ n%0d: got %0d expected %0d", n, occupancy, exp_occ); end
        end
    endtask

    task automatic test_depth1();
        reset1 = 1'b1; iv1 = 1'b0; d1 = 1'b0; or1 = 1'b0;
        @(posedge clock); #1;
        checks++; if (q1 !== 1'b0 || ov1 !== 1'b0) begin errors++; $display("[TB] FAIL d1_reset: got %b/%b expected 0/0", q1, ov1); end
        reset1 = 1'b0; iv1 = 1'b1; d1 = 1'b1;
        #1;
        checks++; if (ir1 !== 1'b1) begin errors++; $display("[TB] FAIL d1_ready_empty: got %b expected 1", ir1); end
        @(posedge clock); #1;
        checks++; if (q1 !== 1'b1 || ov1 !== 1'b1 || occ1 !== 1'b1) begin errors++; $display("[TB] FAIL d1_capture: got %b/%b/%b expected 1/1/1", q1, ov1, occ1); end
        iv1 = 1'b0;
        #1;
        checks++; if (ir1 !== 1'b0) begin errors++; $display("[TB] FAIL d1_ready_full: got %b expected 0", ir1); end
        reset1 = 1'b1; or1 = 1'b1;
        @(posedge clock); #1;
        checks++; if (q1 !== 1'b0 || ov1 !== 1'b0 || occ1 !== 1'b0) begin errors++; $display("[TB] FAIL d1_reset_again: got %b/%b/%b expected 0/0/0", q1, ov1, occ1); end
        reset1 = 1'b0;
    endtask

    initial begin
        $display("[TB] starting ff_pipeline_sync_reset bench");
        test_reset();
        test_streaming();
        test_full_stall();
        test_bubble();
        test_reset_mid();
        test_random();
        test_depth1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
